// File: rtl/frame_reader.sv
// Raster-order frame reader: streams a stored 12-bit RGB frame from a synchronous
// memory with programmable horizontal/vertical blanking and frame markers.
module frame_reader #(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned H_BLANK    = 0,
  parameter int unsigned V_BLANK    = 16,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic                             i_stop,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   o_mem_addr,
  output logic                             o_mem_rd_en,
  input  logic [11:0]                      i_mem_rd_data,
  output logic [11:0]                      o_pixel_out,
  output logic                             o_out_ready,
  output logic                             o_sof,
  output logic                             o_eol,
  output logic                             o_frame_done,
  output logic                             o_busy
);

  localparam int unsigned AW        = $clog2(IMG_W*IMG_H);
  localparam int unsigned CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_col, w_col_nxt;
  logic [RW-1:0]   r_row, w_row_nxt;
  logic [BW-1:0]   r_blank_cnt, w_blank_cnt_nxt;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic            r_mem_rd_en, w_mem_rd_en_nxt;

  logic            r_s1_valid, r_s1_sof, r_s1_eol, r_s1_last;
  logic [11:0]     r_pixel_out;
  logic            r_out_ready, r_sof, r_eol, r_frame_done, r_busy;

  logic            w_col_last, w_row_last, w_restart;
  logic            w_rd_sof, w_rd_eol, w_rd_last;
  logic            w_s1_valid_nxt, w_out_ready_nxt, w_busy_nxt;

  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_restart  = (CONTINUOUS != 0) || i_start;

  // Position flags of the read currently on the memory port
  assign w_rd_sof  = (r_col == '0) && (r_row == '0);
  assign w_rd_eol  = w_col_last;
  assign w_rd_last = w_col_last && w_row_last;

  assign w_s1_valid_nxt  = r_mem_rd_en & ~i_stop;
  assign w_out_ready_nxt = r_s1_valid & ~i_stop;

  // Next-state, read address and read strobe
  always_comb begin
    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_blank_cnt_nxt = r_blank_cnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_rd_en_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt     = S_ACTIVE;
          w_col_nxt       = '0;
          w_row_nxt       = '0;
          w_mem_addr_nxt  = '0;
          w_mem_rd_en_nxt = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!w_col_last) begin
          w_col_nxt       = r_col + CW'(1);
          w_mem_addr_nxt  = r_mem_addr + AW'(1);
          w_mem_rd_en_nxt = 1'b1;
        end else if (!w_row_last) begin
          w_col_nxt = '0;
          w_row_nxt = r_row + RW'(1);
          if (H_BLANK > 0) begin
            w_state_nxt     = S_HBLANK;
            w_blank_cnt_nxt = BW'(H_BLANK - 1);
          end else begin
            w_mem_addr_nxt  = r_mem_addr + AW'(1);
            w_mem_rd_en_nxt = 1'b1;
          end
        end else if (V_BLANK > 0) begin
          w_state_nxt     = S_VBLANK;
          w_blank_cnt_nxt = BW'(V_BLANK - 1);
        end else if (w_restart) begin
          w_col_nxt       = '0;
          w_row_nxt       = '0;
          w_mem_addr_nxt  = '0;
          w_mem_rd_en_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HBLANK: begin
        if (r_blank_cnt == '0) begin
          w_state_nxt     = S_ACTIVE;
          w_mem_addr_nxt  = r_mem_addr + AW'(1);
          w_mem_rd_en_nxt = 1'b1;
        end else begin
          w_blank_cnt_nxt = r_blank_cnt - BW'(1);
        end
      end
      S_VBLANK: begin
        if (r_blank_cnt != '0) begin
          w_blank_cnt_nxt = r_blank_cnt - BW'(1);
        end else if (w_restart) begin
          w_state_nxt     = S_ACTIVE;
          w_col_nxt       = '0;
          w_row_nxt       = '0;
          w_mem_addr_nxt  = '0;
          w_mem_rd_en_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort wins over everything, including a simultaneous start
    if (i_stop) begin
      w_state_nxt     = S_IDLE;
      w_col_nxt       = '0;
      w_row_nxt       = '0;
      w_blank_cnt_nxt = '0;
      w_mem_rd_en_nxt = 1'b0;
    end
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE) | w_mem_rd_en_nxt |
                      w_s1_valid_nxt | w_out_ready_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_blank_cnt <= '0;
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
    end
  end

  // Two-stage output pipeline: flags travel with the read, data joins at stage 2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sof     <= 1'b0;
      r_s1_eol     <= 1'b0;
      r_s1_last    <= 1'b0;
      r_pixel_out  <= '0;
      r_out_ready  <= 1'b0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_s1_valid   <= w_s1_valid_nxt;
      r_s1_sof     <= w_rd_sof;
      r_s1_eol     <= w_rd_eol;
      r_s1_last    <= w_rd_last;
      if (w_out_ready_nxt) begin
        r_pixel_out <= i_mem_rd_data;
      end
      r_out_ready  <= w_out_ready_nxt;
      r_sof        <= w_out_ready_nxt & r_s1_sof;
      r_eol        <= w_out_ready_nxt & r_s1_eol;
      r_frame_done <= w_out_ready_nxt & r_s1_last;
      r_busy       <= w_busy_nxt;
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd_en  = r_mem_rd_en;
  assign o_pixel_out  = r_pixel_out;
  assign o_out_ready  = r_out_ready;
  assign o_sof        = r_sof;
  assign o_eol        = r_eol;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule

// File: doc/frame_reader.md
# frame_reader

Pixel-stream transmitter at the head of the video pipeline. Reads a stored 12-bit RGB frame from a synchronous-read memory in raster order and emits one pixel per active cycle as `pixel_out` / `out_ready`. This is the same valid-only interface consumed by `rgb_to_grey`. Inserts programmable horizontal and vertical blanking so downstream line-buffered stages (`edge_filter`, `calc_centroid`) see a well-formed frame. Provides start-of-frame, end-of-line and frame-done markers aligned to the pixel stream.

## Interface
- `IMG_W`, 640, active pixels per row (≥2)
- `IMG_H`, 480, active rows per frame (≥2)
- `H_BLANK`, 0, idle cycles inserted after every row except the last
- `V_BLANK`, 16, idle cycles inserted after the last row of each frame
- `CONTINUOUS`, 0, 1 = restart automatically after `V_BLANK`; 0 = return to IDLE
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  level-sampled; begins a frame when in IDLE
- `stop`  in  1  synchronous abort; returns to IDLE and discards in-flight pixels
- `mem_addr`  out  $clog2(IMG_W*IMG_H)  read address, registered
- `mem_rd_en`  out  1  read strobe, registered
- `mem_rd_data`  in  12  memory data; valid exactly 1 cycle after `mem_rd_en`
- `pixel_out`  out  12  RGB pixel, registered
- `out_ready`  out  1  `pixel_out` valid this cycle
- `sof`  out  1  with `out_ready`: pixel (0,0)
- `eol`  out  1  with `out_ready`: last pixel of a row
- `frame_done`  out  1  with `out_ready`: pixel (IMG_W-1, IMG_H-1)
- `busy`  out  1  high in any non-IDLE state or while pipeline holds valid data

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - `start`=1 and `stop`=0 → ACTIVE with col=row=0 and `mem_addr`=0.
- ACTIVE:
  - One read per cycle: `mem_rd_en`=1 and `mem_addr` = row*IMG_W+col. The address is maintained as an incrementing counter, not a multiply.
  - col < IMG_W-1: col+1.
  - col = IMG_W-1, row < IMG_H-1: col=0, row+1; go to HBLANK if H_BLANK>0, else stay in ACTIVE.
  - col = IMG_W-1, row = IMG_H-1: go to VBLANK if V_BLANK>0; otherwise follow the VBLANK exit rule directly.
- HBLANK: `mem_rd_en`=0 for exactly H_BLANK cycles (down-counter), then ACTIVE.
- VBLANK: `mem_rd_en`=0 for exactly V_BLANK cycles.
  - Exit to ACTIVE (address 0) if CONTINUOUS=1 or `start`=1 on the final cycle.
  - Otherwise exit to IDLE.
- `mem_addr` never exceeds IMG_W*IMG_H-1. It holds its last value while `mem_rd_en`=0.
- Output pipeline, 2 stages:
  - Stage 1 registers {rd_en, sof, eol, last} alongside the read.
  - Stage 2 captures `mem_rd_data` into `pixel_out` and drives `out_ready`, `sof`, `eol`, `frame_done`.
  - `pixel_out` holds its value when `out_ready`=0.
- `stop` (any state):
  - At that edge: state → IDLE, `mem_rd_en`→0, both pipeline valid bits cleared.
  - `out_ready`, `sof`, `eol`, `frame_done` are 0 from that edge on.
  - `stop` beats `start` when both are sampled together.
- `start` is ignored outside IDLE and on VBLANK cycles other than the final one.
- No backpressure: downstream must accept every `out_ready` pixel.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE; counters 0.
  - `mem_addr`=0, `mem_rd_en`=0, `pixel_out`=0, `out_ready`=0, `sof`=0, `eol`=0, `frame_done`=0, `busy`=0.
  - Reset released mid-frame restarts from IDLE; no partial frame is resumed.
- Latency:
  - `start` sampled at edge E0 → `mem_rd_en`=1 / `mem_addr`=0 after E0.
  - Data presented by memory after E1.
  - `out_ready`=1, `sof`=1, `pixel_out`=mem[0] after E2.
  - Overall: 2 cycles from a read strobe to its pixel.
- Within a row, `out_ready` is continuous for IMG_W cycles.
- Between rows: exactly H_BLANK low cycles.
- Frame period: IMG_W*IMG_H + (IMG_H-1)*H_BLANK + V_BLANK cycles in CONTINUOUS mode.
- `eol` and `frame_done` coincide on the final pixel. `sof` and `eol` never coincide (IMG_W≥2).
- `busy` drops 2 cycles after the last read when returning to IDLE. It drops after the `stop` edge.

## Test plan
- Use IMG_W=4, IMG_H=3, H_BLANK=2, V_BLANK=3, CONTINUOUS=0. Memory content is mem[a]=a.
- Reset values: hold `rst`=0 with `start`=1 → every output is 0. Assert `rst`=0 mid-frame → outputs 0 asynchronously, before the next edge.
- Single frame: pulse `start` → first `out_ready` 2 cycles after the first `mem_rd_en`. Then `pixel_out` sequence 0..11 in bursts of 4, separated by exactly 2 idle cycles. `sof` on 0, `eol` on 3/7/11, `frame_done` on 11. IDLE after 3 VBLANK cycles; `busy` low afterwards.
- Continuous mode (CONTINUOUS=1): two frames back-to-back. Gap between pixel 11 and the next pixel 0 is exactly 3 cycles; second `sof` asserted; `mem_addr` wraps to 0.
- Abort: assert `stop` while `mem_addr`=5 → `out_ready` is 0 from that edge on. Pixels 4/5 in flight are never emitted. State IDLE; a later `start` restarts at pixel 0.
- Arbitration: `start` and `stop` high together in IDLE → remains IDLE, no `mem_rd_en`. `start` pulsed mid-frame → ignored; frame completes normally with 12 pixels.
- Zero blanking (H_BLANK=0, V_BLANK=0, CONTINUOUS=1) → `out_ready` never deasserts after the first pixel. Pixel sequence 0..11,0..11 continuous; `frame_done` and `sof` on adjacent cycles.
